// File: rtl/bloque_cache_pkg.sv
// bloque_cache_pkg: FSM states, default widths and the address tag/index split
package bloque_cache_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_INDEX_W = 4;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2,
        RESP   = 2'd3
    } state_e;

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int index_w);
        return a >> index_w;
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int index_w);
        return a & ((32'd1 << index_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bloque_cache_ctrl_lines.sv
// cache_line_array: valid/tag/data storage with one write port and a combinational hit lookup
module cache_line_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               gen_reset,
    input  logic               wr_en,
    input  logic               set_valid,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic [DATA_W-1:0]  rd_data
);
    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [DATA_W-1:0] data_d [LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_index] = valid_q[wr_index] | set_valid;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
    end

    // only the valid bits need reset; tag/data are meaningless until valid is set
    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) valid_q <= '0;
        else           valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_hit  = valid_q[rd_index] && tag_q[rd_index] == rd_tag;
    assign rd_data = data_q[rd_index];

endmodule

// File: rtl/bloque_cache_ctrl.sv
// bloque_cache_ctrl: direct-mapped write-through no-write-allocate cache controller with saturating hit/miss counters
module bloque_cache_ctrl
    import bloque_cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              gen_reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adress,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_adress,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int TAG_W  = ADDR_W - INDEX_W;
    localparam int WAIT_W = $clog2(MEM_LAT + 2);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_adress_q, mem_adress_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mem_data_in_q, mem_data_in_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              ready_q, ready_d, wr_hit_q, wr_hit_d;
    logic              accept, rd_last, lu_hit, line_we;
    logic [DATA_W-1:0] lu_data, line_data;
    logic [INDEX_W-1:0] lu_index, st_index;
    logic [TAG_W-1:0]   lu_tag, st_tag;

    assign lu_index = INDEX_W'(addr_index(32'(cpu_adress), INDEX_W));
    assign lu_tag   = TAG_W'(addr_tag(32'(cpu_adress), INDEX_W));
    assign st_index = INDEX_W'(addr_index(32'(addr_q), INDEX_W));
    assign st_tag   = TAG_W'(addr_tag(32'(addr_q), INDEX_W));

    cache_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lines (
        .clk       (clk),
        .gen_reset (gen_reset),
        .wr_en     (line_we),
        .set_valid (state_q == MEM_RD),
        .wr_index  (st_index),
        .wr_tag    (st_tag),
        .wr_data   (line_data),
        .rd_index  (lu_index),
        .rd_tag    (lu_tag),
        .rd_hit    (lu_hit),
        .rd_data   (lu_data)
    );

    always_comb begin
        accept        = cpu_req_valid && ready_q;
        rd_last       = state_q == MEM_RD && wait_q == WAIT_W'(MEM_LAT);
        state_d       = state_q == IDLE   ? (accept ? (cpu_we ? MEM_WR : lu_hit ? RESP : MEM_RD) : IDLE)
                      : state_q == MEM_RD ? (rd_last ? RESP : MEM_RD)
                      : state_q == MEM_WR ? RESP : IDLE;
        wait_d        = state_q == MEM_RD ? wait_q + 1'b1 : '0;
        addr_d        = accept ? cpu_adress : addr_q;
        wdata_d       = accept ? cpu_wdata : wdata_q;
        wr_hit_d      = accept ? lu_hit : wr_hit_q;
        // the RAM bus is only reloaded for transactions that use it, so it holds otherwise
        mem_adress_d  = accept && (cpu_we || !lu_hit) ? cpu_adress : mem_adress_q;
        mem_data_in_d = accept && cpu_we ? cpu_wdata : mem_data_in_q;
        rdata_d       = accept && !cpu_we && lu_hit ? lu_data
                      : rd_last ? mem_data_out
                      : state_q == MEM_WR ? wdata_q : rdata_q;
        hit_cnt_d     = accept && lu_hit && !(&hit_cnt_q) ? hit_cnt_q + 1'b1 : hit_cnt_q;
        miss_cnt_d    = accept && !lu_hit && !(&miss_cnt_q) ? miss_cnt_q + 1'b1 : miss_cnt_q;
        ready_d       = state_d == IDLE;
        line_we       = rd_last || (state_q == MEM_WR && wr_hit_q);
        line_data     = rd_last ? mem_data_out : wdata_q;
    end

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_hit_q      <= 1'b0;
            mem_adress_q  <= '0;
            mem_data_in_q <= '0;
            rdata_q       <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wr_hit_q      <= wr_hit_d;
            mem_adress_q  <= mem_adress_d;
            mem_data_in_q <= mem_data_in_d;
            rdata_q       <= rdata_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            ready_q       <= ready_d;
        end
    end

    assign cpu_req_ready    = ready_q;
    assign cpu_resp_valid   = state_q == RESP;
    assign cpu_rdata        = rdata_q;
    assign mem_read_enable  = state_q == MEM_RD;
    assign mem_write_enable = state_q == MEM_WR;
    assign mem_adress       = mem_adress_q;
    assign mem_data_in      = mem_data_in_q;
    assign hit_count        = hit_cnt_q;
    assign miss_count       = miss_cnt_q;

endmodule

// File: doc/bloque_cache_ctrl.md
Name: bloque_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate cache controller. It sits between the CPU request port and the word-addressed RAM block. It is the initiator on the RAM interface and drives write_enable, read_enable, adress and data_in into the RAM, which returns data_out. The block also keeps saturating hit and miss counters for performance checks.

Parameters:
ADDR_W, 10, word-address width (matches the RAM address width)
DATA_W, 32, data word width
INDEX_W, 4, line-index width; the cache has 2**INDEX_W one-word lines
MEM_LAT, 1, RAM read latency in cycles from read_enable sampled to data_out valid
CNT_W, 16, width of the hit and miss counters

Ports:
clk  in  1  system clock, rising edge
gen_reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller can accept a request (high only in IDLE)
cpu_we  in  1  1 = write, 0 = read
cpu_adress  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data; on a write, echoes the written data
mem_write_enable  out  1  RAM write strobe
mem_read_enable  out  1  RAM read strobe
mem_adress  out  ADDR_W  RAM address
mem_data_in  out  DATA_W  data to RAM
mem_data_out  in  DATA_W  data from RAM
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address split: index = cpu_adress[INDEX_W-1:0]; tag = cpu_adress[ADDR_W-1:INDEX_W].
- Storage per line: valid bit, tag and data word.
- Hit rule: the line at the index is valid and its tag matches.
- Reset (asynchronous): all valid bits are cleared, state goes to IDLE, and every output is 0, including both counters and cpu_req_ready. cpu_req_ready rises in the first cycle after deassertion.
- Reset mid-operation: the transaction is abandoned. The mem enables drop immediately, and no cpu_resp_valid is issued.
- FSM states are IDLE, MEM_RD, MEM_WR and RESP.
- IDLE:
  - cpu_req_ready = 1.
  - A request is accepted at a rising edge where valid && ready; address, we and wdata are latched.
  - Read hit: go to RESP; cpu_rdata takes the line data; hit_count increments.
  - Read miss: go to MEM_RD; miss_count increments.
  - Write: go to MEM_WR. hit_count increments on a write hit; miss_count increments on a write miss.
- MEM_RD:
  - mem_read_enable = 1 and mem_adress = latched address, held for MEM_LAT+1 cycles (wait counter).
  - mem_data_out is sampled at the final edge. That edge writes the line (data, tag, valid = 1), loads cpu_rdata, and moves to RESP.
- MEM_WR:
  - For exactly one cycle: mem_write_enable = 1, mem_adress = latched address, mem_data_in = latched wdata.
  - On a write hit, the line data is updated at the exit edge.
  - On a write miss, no line is allocated or changed.
  - cpu_rdata = wdata; the state moves to RESP.
- RESP: cpu_resp_valid = 1 for one cycle, cpu_req_ready = 0, then back to IDLE.
- Latency from the accept edge to the cycle where cpu_resp_valid is high:
  - read hit: 1 cycle
  - read miss: MEM_LAT+2 cycles
  - write: 2 cycles
- Maximum throughput is one request per 2 cycles.
- mem_read_enable and mem_write_enable are never high together, and both are 0 outside MEM_RD/MEM_WR.
- mem_adress and mem_data_in hold their last value when idle.
- cpu_rdata holds until the next response.
- Counters saturate at all-ones; there is no wrap-around.
- cpu_req_valid while not ready is ignored. The CPU holds the request until it is accepted.
- All outputs are registered or decoded directly from the state register; there is no combinational path from cpu_* inputs to mem_* outputs.

Decomposition:
- Package bloque_cache_pkg holds:
  - the state enum (IDLE, MEM_RD, MEM_WR, RESP)
  - default ADDR_W, DATA_W, INDEX_W and CNT_W constants
  - a function that splits an address into tag and index
- Sub-module cache_line_array holds the valid/tag/data arrays:
  - one write port (index, tag, data, set_valid)
  - one combinational read port giving hit and data
  - valid bits cleared asynchronously by gen_reset

Test Plan:
1. Reset, with the RAM preloaded mem[0x003] = 0xAAAA0003; read 0x003 -> miss. mem_read_enable is high 2 cycles with mem_adress = 0x003. cpu_resp_valid is high 3 cycles after accept with rdata 0xAAAA0003. miss_count = 1.
2. Read 0x003 again -> no mem strobe. cpu_resp_valid is high the next cycle with 0xAAAA0003. hit_count = 1.
3. Write 0x011, data 15 (miss) -> one cycle of mem_write_enable with adress 0x011 and data_in 15; no allocate. Then read 0x011 -> miss returning 15; miss_count = 3.
4. Conflict check: read 0x021 (index 1, evicts 0x011). Write 0x021, data 80 -> hit; the line is updated and the RAM is written. Read 0x021 -> hit returning 80 with no mem strobe. Read 0x011 -> miss.
5. Assert gen_reset during MEM_RD -> mem_read_enable drops in the same cycle, no cpu_resp_valid, both counters = 0. A read of 0x003 afterwards is a miss.
6. With CNT_W = 4: 17 read hits -> hit_count stops at 0xF. miss_count is unaffected.
